// File: rtl/upzero_pkg.sv
// Shared definitions for the upzero band scheduler: FSM encoding, band ids,
// default sizing and the round-robin pick used by the arbiter.
package upzero_pkg;

  localparam int DLT_W_DEF          = 17;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int CNT_W_DEF          = 8;

  localparam logic BAND_LO = 1'b0;
  localparam logic BAND_HI = 1'b1;

  // One-hot encoding, same shape as the HLS-generated controllers around it.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_ISSUE     = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_RETIRE    = 4'b1000
  } state_t;

  // Sole requester wins; on a tie the band not served last time wins.
  function automatic logic pick_band(input logic lo_pend,
                                     input logic hi_pend,
                                     input logic last_grant);
    if (lo_pend && hi_pend) return ~last_grant;
    return hi_pend ? BAND_HI : BAND_LO;
  endfunction

endpackage

// File: rtl/upzero_req_slot.sv
// One-entry request holding register: captures data on valid && ready and
// stays pending until the scheduler clears it. No bypass from valid to ready.
module upzero_req_slot
  import upzero_pkg::*;
#(
  parameter int W = DLT_W_DEF
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         valid,
  input  logic [W-1:0] data,
  input  logic         clr,
  output logic         ready,
  output logic         pending,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the data register is reset too, since it is a
  // single word and a defined core_dlt after reset is worth the flops.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pending <= 1'b0;
      q       <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (valid && !pending) begin
      pending <= 1'b1;
      q       <= data;
    end
  end

  assign ready = ~pending;

endmodule

// File: rtl/upzero_band_sched.sv
// Round-robin scheduler placing low/high-band zero-section updates onto one
// shared upzero core, with ap_start/ap_done handshake and a done watchdog.
module upzero_band_sched
  import upzero_pkg::*;
#(
  parameter int DLT_W          = DLT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             lo_valid,
  input  logic [DLT_W-1:0] lo_dlt,
  output logic             lo_ready,
  input  logic             hi_valid,
  input  logic [DLT_W-1:0] hi_dlt,
  output logic             hi_ready,
  output logic             core_start,
  output logic [DLT_W-1:0] core_dlt,
  input  logic             core_done,
  input  logic             core_idle,
  input  logic             core_ready,
  output logic             bank_sel,
  output logic             lo_done,
  output logic             hi_done,
  output logic             busy,
  input  logic             err_clr,
  output logic             err_timeout
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             last_grant;
  logic             done_seen;
  logic [CNT_W-1:0] wd_cnt;
  logic             lo_pend, hi_pend;
  logic [DLT_W-1:0] lo_q, hi_q;
  logic             grant, done_any, wd_fire, slot_clr;
  logic             unused_core_idle;

  upzero_req_slot #(.W(DLT_W)) u_lo_slot (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .valid   (lo_valid),
    .data    (lo_dlt),
    .clr     (slot_clr && (bank_sel == BAND_LO)),
    .ready   (lo_ready),
    .pending (lo_pend),
    .q       (lo_q)
  );

  upzero_req_slot #(.W(DLT_W)) u_hi_slot (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .valid   (hi_valid),
    .data    (hi_dlt),
    .clr     (slot_clr && (bank_sel == BAND_HI)),
    .ready   (hi_ready),
    .pending (hi_pend),
    .q       (hi_q)
  );

  // core_idle is observation-only; the handshake relies on ready/done.
  assign unused_core_idle = core_idle;

  assign grant    = pick_band(lo_pend, hi_pend, last_grant);
  assign done_any = core_done | done_seen;
  assign wd_fire  = (state == ST_WAIT_DONE) && !done_any && (wd_cnt == WD_LAST);
  // The granted slot is freed on retirement and on a watchdog abort alike.
  assign slot_clr = (state == ST_RETIRE) || wd_fire;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= ST_IDLE;
      last_grant <= BAND_HI;
      bank_sel   <= BAND_LO;
      core_dlt   <= '0;
      core_start <= 1'b0;
      done_seen  <= 1'b0;
      wd_cnt     <= '0;
      lo_done    <= 1'b0;
      hi_done    <= 1'b0;
    end else begin
      lo_done <= 1'b0;
      hi_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (lo_pend || hi_pend) begin
            bank_sel   <= grant;
            last_grant <= grant;
            core_dlt   <= (grant == BAND_HI) ? hi_q : lo_q;
            core_start <= 1'b1;
            done_seen  <= 1'b0;
            wd_cnt     <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A done arriving together with ready is latched so WAIT_DONE
          // retires on its first cycle instead of waiting for another done.
          if (core_ready || core_done) begin
            core_start <= 1'b0;
            done_seen  <= core_done;
            state      <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (done_any) begin
            lo_done <= (bank_sel == BAND_LO);
            hi_done <= (bank_sel == BAND_HI);
            state   <= ST_RETIRE;
          end else if (wd_fire) begin
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RETIRE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Sticky watchdog flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)       err_timeout <= 1'b0;
    else if (wd_fire) err_timeout <= 1'b1;
    else if (err_clr) err_timeout <= 1'b0;
  end

endmodule

// File: doc/upzero_band_sched.md
Name: upzero_band_sched

Overview:
- Scheduler in front of a single shared upzero core in the ADPCM datapath.
- Accepts zero-section update requests from the low-band and high-band paths, each carrying a 17-bit dlt.
- Holds each request in a one-entry slot, grants the core round-robin and drives its ap_start/ap_done handshake.
- Drives bank_sel so external muxes steer the core's dlti/bli ports to the granted band's memories, and returns a per-band completion pulse.

Parameters:
- DLT_W, 17, width of the dlt operand; matches the core's dlt input.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT_DONE before the watchdog fires. Legal range is 16 to 255; the core's worst case is about 30 cycles.
- CNT_W, 8, watchdog counter width.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset, asynchronous, active-high.
- lo_valid  in  1  low-band request valid.
- lo_dlt  in  DLT_W  low-band dlt, signed.
- lo_ready  out  1  low-band slot empty.
- hi_valid  in  1  high-band request valid.
- hi_dlt  in  DLT_W  high-band dlt, signed.
- hi_ready  out  1  high-band slot empty.
- core_start  out  1  to core ap_start.
- core_dlt  out  DLT_W  to core dlt; registered.
- core_done  in  1  from core ap_done.
- core_idle  in  1  from core ap_idle.
- core_ready  in  1  from core ap_ready.
- bank_sel  out  1  0 = low-band memories, 1 = high-band memories.
- lo_done  out  1  one-cycle pulse when a low-band update completes.
- hi_done  out  1  one-cycle pulse when a high-band update completes.
- busy  out  1  high in every state except IDLE.
- err_clr  in  1  clears err_timeout.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0, except lo_ready = 1 and hi_ready = 1. Slots empty, state IDLE, last_grant = 1 (so low band wins the first tie), counter 0.
- Acceptance:
  - A request is accepted when valid and ready are both high at the clock edge; dlt is captured into the band's slot and the slot is marked pending.
  - ready = not pending; no bypass path.
  - Both bands may be accepted in the same cycle.
- State machine: IDLE, ISSUE, WAIT_DONE, RETIRE.
- IDLE:
  - If no slot is pending, stay in IDLE.
  - If exactly one slot is pending, grant that band.
  - If both are pending, grant the band opposite last_grant.
  - On grant: register core_dlt and bank_sel, update last_grant, go to ISSUE.
  - Grant uses pending state registered before the edge, so a request accepted in this cycle is seen next cycle.
- ISSUE:
  - core_start = 1.
  - Stay until core_ready = 1 or core_done = 1 is seen, then go to WAIT_DONE with core_start deasserting in the same edge.
  - core_done seen in ISSUE is remembered, and WAIT_DONE exits on its next cycle.
- WAIT_DONE:
  - core_start = 0; the counter increments every cycle.
  - On core_done (or the remembered done), go to RETIRE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: set err_timeout, clear the granted slot, emit no done pulse, go to IDLE.
- RETIRE:
  - Clear the granted slot; that band's ready rises on the next cycle.
  - Pulse lo_done or hi_done for exactly 1 cycle, per bank_sel.
  - Go to IDLE. Minimum turnaround is IDLE -> IDLE in 4 cycles.
- bank_sel and core_dlt are held stable from the grant edge through RETIRE, and change only on a grant.
- Width rules: dlt is passed through unchanged, with no sign extension; the core handles that.
- err_timeout: sticky. err_clr clears it; if err_clr and a new timeout occur in the same cycle, the set wins.
- core_idle is monitoring only and does not affect the state machine.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), including core_start. Pending requests are lost, and requesters must reissue.
- A request arriving for a band whose previous request is in flight stalls on ready = 0 until RETIRE + 1.

Decomposition:
- Shared package upzero_pkg holds:
  - the state encoding (one-hot, 4 bits, matching the team's HLS one-hot FSM style);
  - BAND_LO = 0 and BAND_HI = 1;
  - default constants for DLT_W and TIMEOUT_CYCLES.
- One natural sub-module, upzero_req_slot: a one-entry holding register with valid/ready, data and a clear input. It is instantiated twice, once per band.
- The arbiter, FSM and watchdog stay in the top.

Test Plan:
- Single low request: lo_dlt = 17'h00123; core model asserts ready 1 cycle after start and done 12 cycles later.
  -> core_dlt = 17'h00123, bank_sel = 0, core_start high for exactly 2 cycles, lo_done pulses once, lo_ready back to 1.
- Simultaneous lo and hi after reset, dlt 5 and 17'h1FFFB.
  -> low band served first and hi second (bank_sel 0 then 1), core_dlt = 5 then 17'h1FFFB, two done pulses in that order.
- Back-to-back contention: both bands re-request immediately on each done, for 6 rounds.
  -> grants alternate lo, hi, lo, hi, lo, hi; no back-to-back grants to one band.
- Watchdog: core never asserts done, TIMEOUT_CYCLES = 16.
  -> err_timeout rises 16 cycles after entering WAIT_DONE, no done pulse, slot freed. err_clr then drops the flag.
- Reset asserted in WAIT_DONE with hi pending.
  -> core_start, busy and bank_sel go to 0 asynchronously, both ready = 1, no done pulse after release.
- Done coincident with ready in ISSUE (core_ready = core_done = 1 in the same cycle).
  -> RETIRE follows 2 cycles later, with exactly one done pulse and no timeout.
